risac_soc_system_key_pio: RTL and testbench

Avalon-MM slave input port with per-bit edge capture and a level interrupt. It is the receive-direction counterpart of the LED output PIO. It samples asynchronous board inputs (push-buttons, switches) into the `clk` domain and lets the RISAC core read the current level. It latches selected edges into sticky capture bits and raises `irq` for unmasked captured edges. It sits on the system interconnect next to the output PIOs and drives one interrupt-controller input.

---
 rtl/risac_soc_system_key_pio_if.sv | 25 ++
 rtl/risac_soc_system_key_pio.sv | 98 +++++++++
 tb/tb_risac_soc_system_key_pio.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/risac_soc_system_key_pio_if.sv
// Avalon-MM slave bus bundle for the key PIO: word address, select,
// active-low write strobe, 32-bit write data and zero-latency read data.
interface risac_soc_system_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/risac_soc_system_key_pio.sv
// Key/switch input PIO: synchronizes board inputs, latches selected edges
// into sticky write-1-to-clear capture bits and raises a level interrupt for
// captured edges whose mask bit is set.
module risac_soc_system_key_pio #(
    parameter int               WIDTH          = 4,
    parameter int               EDGE_TYPE      = 1,   // 0 rising, 1 falling, 2 any
    parameter logic [WIDTH-1:0] IN_RESET_VALUE = '1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    risac_soc_system_key_pio_if.slave      bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    // Bits of writedata above WIDTH are deliberately ignored by the register map.
    logic unused_writedata;
    assign unused_writedata = ^bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, giving a true pipeline.
        if (!reset_n) begin
            sync1 <= IN_RESET_VALUE;
            sync2 <= IN_RESET_VALUE;
            prev  <= IN_RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Select the configured edge type from the synchronized level and its delay.
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a signal
        // unassigned, which would otherwise infer a latch.
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync2 & ~prev;
            1:       edge_det = ~sync2 & prev;
            default: edge_det = sync2 ^ prev;
        endcase
    end

    // Write-1-to-clear mask for the capture register.
    always_comb begin
        clr = '0;
        if (wr_en && bus.address == ADDR_EDGECAP)
            clr = bus.writedata[WIDTH-1:0];
    end

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq_mask <= '0;
        else if (wr_en && bus.address == ADDR_IRQMASK)
            irq_mask <= bus.writedata[WIDTH-1:0];
    end

    // Sticky edge capture; a new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n)
            edgecapture <= '0;
        else
            edgecapture <= edge_det | (edgecapture & ~clr);
    end

    // Zero-latency read mux, zero-extended to the bus width.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata[WIDTH-1:0] = sync2;
            ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecapture;
            default:      bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_risac_soc_system_key_pio.sv
// Bench for the key PIO. Two instances share the same stimulus: one captures
// falling edges, the other any edge. A pin-history model predicts read data
// and irq for both every cycle; directed reads pin the model to literal values.
module tb_risac_soc_system_key_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic        irq_f;
    logic        irq_a;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    risac_soc_system_key_pio_if bus_f ();
    risac_soc_system_key_pio_if bus_a ();

    assign bus_f.address    = address;
    assign bus_f.chipselect = chipselect;
    assign bus_f.write_n    = write_n;
    assign bus_f.writedata  = writedata;
    assign bus_a.address    = address;
    assign bus_a.chipselect = chipselect;
    assign bus_a.write_n    = write_n;
    assign bus_a.writedata  = writedata;

    risac_soc_system_key_pio #(.WIDTH(4), .EDGE_TYPE(1), .IN_RESET_VALUE(4'hF)) dut_f (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_f.slave),
        .in_port (in_port),
        .irq     (irq_f)
    );

    risac_soc_system_key_pio #(.WIDTH(4), .EDGE_TYPE(2), .IN_RESET_VALUE(4'hF)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave),
        .in_port (in_port),
        .irq     (irq_a)
    );

    // ---------------- behavioural model ----------------
    // pin_hist[k] is the pin level as sampled k+1 clock edges ago; software
    // sees a level two edges after it is sampled, and an edge is the change
    // between the level software sees now and the one it saw a cycle earlier.
    logic [3:0] pin_hist [3];
    logic [3:0] m_mask;
    logic [3:0] m_cap [2];   // [0] falling-edge instance, [1] any-edge instance
    logic       m_valid = 1'b0;

    function automatic logic [3:0] next_cap(input int kind, input logic [3:0] seen_now,
                                            input logic [3:0] seen_before, input logic [3:0] old,
                                            input logic [3:0] clr);
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) begin
            if (kind == 1) ev[i] = (seen_before[i] == 1'b1) && (seen_now[i] == 1'b0);
            else           ev[i] = (seen_before[i] != seen_now[i]);
        end
        return ev | (old & ~clr);
    endfunction

    always @(posedge clk) begin
        logic [3:0] clr;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) pin_hist[k] <= 4'hF;
            m_mask   <= 4'h0;
            m_cap[0] <= 4'h0;
            m_cap[1] <= 4'h0;
            m_valid  <= 1'b1;
        end else begin
            pin_hist[0] <= in_port;
            pin_hist[1] <= pin_hist[0];
            pin_hist[2] <= pin_hist[1];
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
            m_cap[0] <= next_cap(1, pin_hist[1], pin_hist[2], m_cap[0], clr);
            m_cap[1] <= next_cap(2, pin_hist[1], pin_hist[2], m_cap[1], clr);
        end
    end

    function automatic logic [31:0] model_read(input int d, input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, pin_hist[1]};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_cap[d]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc rd_f", bus_f.readdata, model_read(0, address));
            check("cyc rd_a", bus_a.readdata, model_read(1, address));
            check("cyc irq_f", {31'h0, irq_f}, {31'h0, |(m_cap[0] & m_mask)});
            check("cyc irq_a", {31'h0, irq_a}, {31'h0, |(m_cap[1] & m_mask)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Read both instances in the current cycle against hand-computed values.
    task automatic rd_now(input string name, input logic [1:0] a,
                          input logic [31:0] exp_f, input logic [31:0] exp_a);
        address    = a;
        chipselect = 1'b1;
        #1;
        check({name, "_f"}, bus_f.readdata, exp_f);
        check({name, "_a"}, bus_a.readdata, exp_a);
        chipselect = 1'b0;
    endtask

    task automatic irq_now(input string name, input logic exp_f, input logic exp_a);
        check({name, "_f"}, {31'h0, irq_f}, {31'h0, exp_f});
        check({name, "_a"}, {31'h0, irq_a}, {31'h0, exp_a});
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state and no false capture on leaving reset.
        step(5);
        rd_now("reset data", 2'd0, 32'hF, 32'hF);
        rd_now("reset rsvd", 2'd1, 32'h0, 32'h0);
        rd_now("reset mask", 2'd2, 32'h0, 32'h0);
        rd_now("reset cap",  2'd3, 32'h0, 32'h0);
        irq_now("reset irq", 1'b0, 1'b0);

        // Falling capture with N / N+1 / N+2 timing.
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        step(1);                                  // edge N: first sync stage
        rd_now("edge N data", 2'd0, 32'hF, 32'hF);
        step(1);                                  // edge N+1: level visible
        rd_now("edge N1 data", 2'd0, 32'hE, 32'hE);
        rd_now("edge N1 cap", 2'd3, 32'h0, 32'h0);
        irq_now("edge N1 irq", 1'b0, 1'b0);
        step(1);                                  // edge N+2: captured
        rd_now("edge N2 cap", 2'd3, 32'h1, 32'h1);
        irq_now("edge N2 irq", 1'b1, 1'b1);
        in_port = 4'hF;
        step(4);
        rd_now("return edge cap", 2'd3, 32'h1, 32'h1);

        // W1C behaviour from a capture of 0x5.
        in_port = 4'hB;
        step(3);
        in_port = 4'hF;
        step(3);
        rd_now("cap 0x5", 2'd3, 32'h5, 32'h5);
        wr(2'd3, 32'h4);
        rd_now("w1c bit2", 2'd3, 32'h1, 32'h1);
        wr(2'd3, 32'h0);
        rd_now("w1c zero", 2'd3, 32'h1, 32'h1);

        // Clear of bit 1 in the same cycle a new falling edge captures it.
        in_port = 4'hD;
        step(3);
        in_port = 4'hF;
        step(3);
        rd_now("cap 0x3", 2'd3, 32'h3, 32'h3);
        in_port = 4'hD;
        step(2);                                  // next edge is N+2
        wr(2'd3, 32'h2);
        rd_now("clr vs edge", 2'd3, 32'h3, 32'h3);
        wr(2'd3, 32'h2);
        rd_now("clr bit1", 2'd3, 32'h1, 32'h1);
        in_port = 4'hF;
        step(3);
        rd_now("rise after clr", 2'd3, 32'h1, 32'h3);

        // Masking with a pending capture.
        wr(2'd3, 32'hF);
        rd_now("clr all", 2'd3, 32'h0, 32'h0);
        in_port = 4'hD;
        step(3);
        in_port = 4'hF;
        step(3);
        wr(2'd2, 32'h2);
        rd_now("mask cap", 2'd3, 32'h2, 32'h2);
        irq_now("mask on irq", 1'b1, 1'b1);
        wr(2'd2, 32'h0);
        irq_now("mask off irq", 1'b0, 1'b0);
        rd_now("mask off cap", 2'd3, 32'h2, 32'h2);
        wr(2'd2, 32'h2);
        irq_now("mask re-on irq", 1'b1, 1'b1);

        // Toggle of bit 3, then reset in the same cycle as a mask write.
        wr(2'd3, 32'hF);
        irq_now("cleared irq", 1'b0, 1'b0);
        in_port = 4'h7;
        step(4);
        in_port = 4'hF;
        step(4);
        rd_now("toggle bit3", 2'd3, 32'h8, 32'h8);
        address    = 2'd2;
        writedata  = 32'hF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        reset_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        rd_now("rst mask", 2'd2, 32'h0, 32'h0);
        rd_now("rst cap",  2'd3, 32'h0, 32'h0);
        rd_now("rst data", 2'd0, 32'hF, 32'hF);
        irq_now("rst irq", 1'b0, 1'b0);
        step(3);

        // Upper write bits ignored; DATA and reserved are not writable.
        wr(2'd2, 32'hFFFF_FFF0);
        rd_now("mask upper", 2'd2, 32'h0, 32'h0);
        wr(2'd0, 32'h0);
        rd_now("data ro", 2'd0, 32'hF, 32'hF);
        wr(2'd1, 32'h5);
        rd_now("rsvd", 2'd1, 32'h0, 32'h0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
